// File: rtl/lt_arbiter.sv
// ---------------------------------------------------------------------------
// lt_arbiter: round-robin arbiter in front of a single unsigned less-than
// comparator. One requester is accepted at a time. Its operands are captured,
// compared in the following cycle, and the result is held until the consumer
// takes it.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous reset, active low
//   req_valid  : [R]   requester i presents an operand pair
//   req_a      : [N*R] requester i operand A at [i*N +: N], unsigned
//   req_b      : [N*R] requester i operand B at [i*N +: N], unsigned
//   req_ready  : [R]   one-hot-or-zero accept strobe (combinational, IDLE only)
//   resp_valid : result available
//   resp_id    : [W]   index of the requester that owns the result
//   resp_lt    : 1 iff captured A < captured B
//   resp_ready : consumer accepts the result
//   busy       : high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------

// Unsigned less-than comparator.
//   a_i, b_i : [N] operands
//   lt_o     : a_i < b_i, unsigned
module comparator_lt_unsigned #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         lt_o
);
  assign lt_o = (a_i < b_i);
endmodule

module lt_arbiter #(
  parameter  int N = 32,
  parameter  int R = 4,
  localparam int W = (R > 1) ? $clog2(R) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  input  logic [N*R-1:0] req_a,
  input  logic [N*R-1:0] req_b,
  output logic [R-1:0]   req_ready,
  output logic           resp_valid,
  output logic [W-1:0]   resp_id,
  output logic           resp_lt,
  input  logic           resp_ready,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [W:0]   R_EXT = (W+1)'(R);
  localparam logic [W-1:0] R_MAX = W'(R - 1);

  state_t         state_q;
  logic [W-1:0]   ptr_q;
  logic [W-1:0]   ptr_d;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [W-1:0]   id_q;
  logic           resp_valid_q;
  logic [W-1:0]   resp_id_q;
  logic           resp_lt_q;

  logic           gnt_found;
  logic [W-1:0]   gnt_idx;
  logic [W:0]     probe;
  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;
  logic           cmp_lt;

  // Rotating priority search: probe ptr, ptr+1, ... (mod R); first hit wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    probe     = '0;
    for (int k = 0; k < R; k++) begin
      probe = {1'b0, ptr_q} + (W+1)'(k);
      if (probe >= R_EXT) probe = probe - R_EXT;
      if (!gnt_found && req_valid[probe[W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = probe[W-1:0];
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < R; k++) begin
      if (gnt_idx == W'(k)) begin
        sel_a = req_a[k*N +: N];
        sel_b = req_b[k*N +: N];
      end
    end
  end

  // Accept strobe only exists in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst && (state_q == IDLE) && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  // Priority moves to the requester after the one just served.
  assign ptr_d = (id_q == R_MAX) ? '0 : id_q + W'(1);

  comparator_lt_unsigned #(.N(N)) u_cmp (
    .a_i  (a_q),
    .b_i  (b_q),
    .lt_o (cmp_lt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_lt_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            id_q    <= gnt_idx;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          resp_lt_q    <= cmp_lt;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          // Result fields return to zero with resp_valid so they are 0 when idle.
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_lt_q    <= 1'b0;
            ptr_q        <= ptr_d;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_lt    = resp_lt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_lt_arbiter.sv
module tb_lt_arbiter;

  localparam int N = 32;
  localparam int R = 4;
  localparam int W = 2;

  logic           clk;
  logic           rst;
  logic [R-1:0]   req_valid;
  logic [N*R-1:0] req_a;
  logic [N*R-1:0] req_b;
  logic [R-1:0]   req_ready;
  logic           resp_valid;
  logic [W-1:0]   resp_id;
  logic           resp_lt;
  logic           resp_ready;
  logic           busy;

  int n_cmp;
  int n_bad;

  lt_arbiter #(.N(N), .R(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_lt    (resp_lt),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          rid;
    logic [31:0] a;
    logic [31:0] b;
    logic        lt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs checked between edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] onehot(input int i);
    logic [31:0] v;
    v = 32'd1 << i;
    return v;
  endfunction

  task automatic set_ops(input int rid, input logic [31:0] a, input logic [31:0] b);
    req_a[rid*N +: N] = a;
    req_b[rid*N +: N] = b;
  endtask

  // Complete single-requester transaction with resp_ready held high.
  task automatic run_txn(input string tag, input int rid, input logic [31:0] a,
                         input logic [31:0] b, input logic exp_lt);
    set_ops(rid, a, b);
    req_valid  = R'(onehot(rid));
    resp_ready = 1'b1;
    #1;
    chk({tag, ".grant"}, 32'(req_ready), onehot(rid));
    chk({tag, ".busyT"}, 32'(busy), 32'd0);
    tick();
    req_valid = '0;
    #1;
    chk({tag, ".execReady"}, 32'(req_ready), 32'd0);
    chk({tag, ".execBusy"}, 32'(busy), 32'd1);
    chk({tag, ".execValid"}, 32'(resp_valid), 32'd0);
    tick();
    chk({tag, ".valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".id"}, 32'(resp_id), 32'(rid));
    chk({tag, ".lt"}, 32'(resp_lt), 32'(exp_lt));
    tick();
    chk({tag, ".idleValid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".idleId"}, 32'(resp_id), 32'd0);
    chk({tag, ".idleLt"}, 32'(resp_lt), 32'd0);
    chk({tag, ".idleBusy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{rid: 0, a: 32'd5,          b: 32'd9,          lt: 1'b1};
    vecs[1] = '{rid: 1, a: 32'd7,          b: 32'd7,          lt: 1'b0};
    vecs[2] = '{rid: 2, a: 32'd0,          b: 32'd0,          lt: 1'b0};
    vecs[3] = '{rid: 3, a: 32'hFFFF_FFFE,  b: 32'hFFFF_FFFF,  lt: 1'b1};
    vecs[4] = '{rid: 0, a: 32'hFFFF_FFFF,  b: 32'd0,          lt: 1'b0};
    vecs[5] = '{rid: 1, a: 32'hFFFF_FFFF,  b: 32'd1,          lt: 1'b0};
    vecs[6] = '{rid: 2, a: 32'h7FFF_FFFF,  b: 32'h8000_0000,  lt: 1'b1};
    vecs[7] = '{rid: 3, a: 32'h8000_0000,  b: 32'h7FFF_FFFF,  lt: 1'b0};

    // Reset with every requester asking: nothing may be accepted.
    rst        = 1'b0;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.valid", 32'(resp_valid), 32'd0);
    chk("rst.id", 32'(resp_id), 32'd0);
    chk("rst.lt", 32'(resp_lt), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    req_valid = '0;
    rst = 1'b1;
    tick();
    chk("idle.noReqReady", 32'(req_ready), 32'd0);
    chk("idle.noReqBusy", 32'(busy), 32'd0);

    // Table-driven single transactions, including unsigned boundaries.
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].rid, vecs[i].a, vecs[i].b, vecs[i].lt);
    end

    // Round robin, all requesters held, grants every 3 cycles: 0,1,2,3,0.
    for (int i = 0; i < R; i++) set_ops(i, 32'd7, 32'd7);
    req_valid  = '1;
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rr%0d.grant", i), 32'(req_ready), onehot(i % R));
      tick();
      chk($sformatf("rr%0d.execReady", i), 32'(req_ready), 32'd0);
      tick();
      chk($sformatf("rr%0d.valid", i), 32'(resp_valid), 32'd1);
      chk($sformatf("rr%0d.id", i), 32'(resp_id), 32'(i % R));
      chk($sformatf("rr%0d.lt", i), 32'(resp_lt), 32'd0);
      chk($sformatf("rr%0d.doneReady", i), 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = '0;
    #1;
    chk("rr.end", 32'(busy), 32'd0);

    // Backpressure plus operand change after grant; ptr is now 1.
    set_ops(1, 32'd3, 32'd50);
    set_ops(2, 32'd10, 32'd4);
    req_valid  = 4'b0110;
    resp_ready = 1'b0;
    #1;
    chk("bp.grant", 32'(req_ready), 32'h2);
    tick();
    req_a[1*N +: N] = 32'd100;
    #1;
    chk("bp.execReady", 32'(req_ready), 32'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d.valid", c), 32'(resp_valid), 32'd1);
      chk($sformatf("bp%0d.id", c), 32'(resp_id), 32'd1);
      chk($sformatf("bp%0d.lt", c), 32'(resp_lt), 32'd1);
      chk($sformatf("bp%0d.ready", c), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d.busy", c), 32'(busy), 32'd1);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp.releaseValid", 32'(resp_valid), 32'd1);
    chk("bp.releaseReady", 32'(req_ready), 32'd0);
    tick();
    chk("bp.nextGrant", 32'(req_ready), 32'h4);
    chk("bp.idleValid", 32'(resp_valid), 32'd0);
    tick();
    req_valid = '0;
    tick();
    chk("bp2.id", 32'(resp_id), 32'd2);
    chk("bp2.lt", 32'(resp_lt), 32'd0);
    tick();

    // Reset during EXEC; ptr is 3 beforehand and must restart at 0.
    set_ops(2, 32'd1, 32'd2);
    req_valid = 4'b0100;
    #1;
    chk("rx.grant", 32'(req_ready), 32'h4);
    tick();
    rst = 1'b0;
    req_valid = '0;
    #1;
    chk("rx.execBusy", 32'(busy), 32'd1);
    tick();
    chk("rx.valid", 32'(resp_valid), 32'd0);
    chk("rx.busy", 32'(busy), 32'd0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rx%0d.noResp", c), 32'(resp_valid), 32'd0);
      tick();
    end
    set_ops(1, 32'd9, 32'd8);
    req_valid = 4'b1010;
    #1;
    chk("rx.ptrZeroGrant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    chk("rx.id", 32'(resp_id), 32'd1);
    chk("rx.lt", 32'(resp_lt), 32'd0);
    tick();
    run_txn("rx3", 3, 32'd4, 32'd6, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lt_arbiter.md
LT_ARBITER -- requirements
Module: lt_arbiter

Interface
REQ-001 Parameter: N, 32, operand width in bits.
REQ-002 Parameter: R, 4, number of requesters; legal range 2..8; ID width W = clog2(R).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-low reset (asserted when rst=0, sampled on rising edge of clk).
REQ-005 Port: req_valid  input  R  bit i = requester i presents an operand pair.
REQ-006 Port: req_a  input  N*R  requester i operand A at bits [i*N +: N], unsigned.
REQ-007 Port: req_b  input  N*R  requester i operand B at bits [i*N +: N], unsigned.
REQ-008 Port: req_ready  output  R  one-hot-or-zero accept strobe; bit i high = requester i accepted this cycle.
REQ-009 Port: resp_valid  output  1  result available.
REQ-010 Port: resp_id  output  W  index of the requester that owns the result.
REQ-011 Port: resp_lt  output  1  1 iff captured A < captured B, unsigned.
REQ-012 Port: resp_ready  input  1  consumer accepts result when resp_valid=1.
REQ-013 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 Exactly one comparator_lt_unsigned #(.N(N)) instance computes all results; operands go to it only from internal capture registers.
REQ-015 FSM states: IDLE, EXEC, DONE; no other reachable states.
REQ-016 IDLE: if any req_valid bit is set, grant g = first set bit searching ptr, ptr+1, ... mod R; req_ready[g]=1 combinationally in the same cycle; capture req_a[g], req_b[g], g; next state EXEC.
REQ-017 IDLE with req_valid=0: req_ready=0, state holds, ptr holds.
REQ-018 req_ready SHALL be 0 in EXEC and DONE regardless of req_valid.
REQ-019 EXEC: register comparator output into resp_lt; next state DONE; lasts exactly one cycle.
REQ-020 DONE: resp_valid=1, resp_id=g, resp_lt stable; hold until resp_ready=1.
REQ-021 DONE with resp_ready=1: next state IDLE, ptr <= (g+1) mod R; no new grant in that same cycle.
REQ-022 Latency: handshake cycle T -> resp_valid first high at T+2; minimum issue interval 3 cycles.
REQ-023 A requester deasserting req_valid before receiving req_ready is legal and forfeits nothing; it is simply not granted.
REQ-024 Captured operands are immune to later changes on req_a/req_b.
REQ-025 Equal operands produce resp_lt=0; A=0,B=0 gives 0; A=2^N-2,B=2^N-1 gives 1; A=2^N-1,B=0 gives 0 (unsigned, no sign interpretation).
REQ-026 ptr wraps from R-1 to 0; a requester holding req_valid continuously is granted within R grants.
REQ-027 resp_valid, resp_id, resp_lt change only on clock edges; resp_id and resp_lt are 0 whenever resp_valid=0.

Reset
REQ-028 rst=0 at a rising edge: state IDLE, ptr=0, capture registers 0, resp_valid=0, resp_id=0, resp_lt=0, busy=0.
REQ-029 req_ready SHALL be 0 during any cycle with rst=0.
REQ-030 Reset mid-operation (EXEC or DONE) discards the pending result; no resp_valid appears after reset release for that request.
REQ-031 First grant after reset release is evaluated with ptr=0.

Verification
REQ-032 Single request: req_valid=0001, A0=5, B0=9, resp_ready=1 -> req_ready=0001 at T, resp_valid=1 at T+2 with resp_id=0, resp_lt=1; IDLE at T+3.
REQ-033 Round-robin: req_valid=1111 held, all operands A=B=7, resp_ready=1 -> grant order 0,1,2,3,0; every resp_lt=0; grants 3 cycles apart.
REQ-034 Unsigned boundary: A=0xFFFFFFFF,B=0x00000001 -> resp_lt=0; A=0x7FFFFFFF,B=0x80000000 -> resp_lt=1.
REQ-035 Backpressure: resp_ready=0 for 5 cycles in DONE, req_valid=0110 -> resp_valid held, resp_id/resp_lt stable, req_ready=0 throughout; after resp_ready=1, next grant goes to (g+1) mod 4 among set bits.
REQ-036 Operand change after grant: req_a[1] 3->100 at T+1 with B1=50 -> resp_lt=1 (captured value 3 used).
REQ-037 Reset in EXEC: rst=0 at T+1 -> resp_valid=0, busy=0 at T+2; with req_valid=1000 after release, grant to 3 (search from ptr=0).
